// File: rtl/simd_loop_iter_ctrl.sv
// simd_loop_iter_ctrl: per-group loop-nest iteration controller feeding the SIMD stride-group walker.
// Optional feature macro: SIMD_ITER_PERF_CNT_EN adds RUN step/stall performance counters.
module simd_loop_iter_ctrl #(
    parameter int LOOP_ID_W      = 5,
    parameter int GROUP_ID_W     = 2,
    parameter int GROUP_ENABLED  = 1,
    parameter int ITER_W         = 16,
    parameter int NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
    parameter int NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_cfg_loop_iter_v,
    input  logic [ITER_W-1:0]        i_cfg_loop_iter,
    input  logic [GROUP_ID_W-1:0]    i_cfg_loop_group_id,
    input  logic                     i_go,
    input  logic [GROUP_ID_W-1:0]    i_go_group_id,
    input  logic                     i_go_last,
    input  logic                     i_stall,
    output logic                     o_busy,
    output logic                     o_start,
    output logic [GROUP_ID_W-1:0]    o_loop_group_id,
    output logic [NUM_MAX_LOOPS:0]   o_iter_done,
    output logic                     o_done,
    output logic                     o_block_done
`ifdef SIMD_ITER_PERF_CNT_EN
    ,
    output logic [31:0]              o_perf_step_cnt,
    output logic [31:0]              o_perf_stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, LAUNCH, ARM, RUN, FIN} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [GROUP_ID_W-1:0]   r_grp;
    logic                    r_last;
    logic [ITER_W-1:0]       r_trips [NUM_MAX_GROUPS][NUM_MAX_LOOPS];
    logic [ITER_W-1:0]       r_cnt   [NUM_MAX_GROUPS][NUM_MAX_LOOPS];
    logic [LOOP_ID_W-1:0]    r_ptr   [NUM_MAX_GROUPS];
    logic [NUM_MAX_LOOPS:0]  w_iter_done;
    logic [GROUP_ID_W-1:0]   w_cfg_g;
    logic [GROUP_ID_W-1:0]   w_go_g;
    logic [LOOP_ID_W-1:0]    w_addr;
    logic                    w_go_ok;
    logic                    w_block_done;

    // Single-group builds fold every group id to 0.
    assign w_cfg_g      = (GROUP_ENABLED != 0) ? i_cfg_loop_group_id : '0;
    assign w_go_g       = (GROUP_ENABLED != 0) ? i_go_group_id : '0;
    assign w_go_ok      = (r_state == IDLE) & i_go;
    assign w_block_done = (r_state == FIN) & r_last;
    // A config write coinciding with block_done lands in loop 0 of the freshly reset pointer.
    assign w_addr       = w_block_done ? '0 : r_ptr[w_cfg_g];

    assign o_busy          = r_state != IDLE;
    assign o_start         = r_state == LAUNCH;
    assign o_done          = r_state == FIN;
    assign o_block_done    = w_block_done;
    assign o_loop_group_id = r_grp;
    assign o_iter_done     = w_iter_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: launch, one dead cycle for the walker's base load, run, finish.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_go ? LAUNCH : IDLE;
            LAUNCH:  w_next = ARM;
            ARM:     w_next = RUN;
            RUN:     w_next = w_iter_done[0] ? FIN : RUN;
            default: w_next = IDLE;
        endcase
    end

    // Wrap chain: a loop wraps when every inner loop wraps and it sits at its trip count.
    always_comb begin
        logic acc;
        w_iter_done = '0;
        acc = (r_state == RUN) & ~i_stall;
        w_iter_done[NUM_MAX_LOOPS] = acc;
        for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) begin
            acc = acc & (r_cnt[r_grp][i] == r_trips[r_grp][i]);
            w_iter_done[i] = acc;
        end
    end

    // Latch the launched group and its end-of-block flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grp  <= '0;
            r_last <= 1'b0;
        end else if (w_go_ok) begin
            r_grp  <= w_go_g;
            r_last <= i_go_last;
        end
    end

    // Per-group counters: advance on inner wrap, cleared only at the group's finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < NUM_MAX_GROUPS; g++)
                for (int i = 0; i < NUM_MAX_LOOPS; i++)
                    r_cnt[g][i] <= '0;
        end else if (r_state == FIN) begin
            for (int i = 0; i < NUM_MAX_LOOPS; i++)
                r_cnt[r_grp][i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MAX_LOOPS; i++)
                if (w_iter_done[i+1])
                    r_cnt[r_grp][i] <= w_iter_done[i] ? '0 : r_cnt[r_grp][i] + ITER_W'(1);
        end
    end

    // Trip-count table and saturating per-group write pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
                r_ptr[g] <= '0;
                for (int i = 0; i < NUM_MAX_LOOPS; i++)
                    r_trips[g][i] <= '0;
            end
        end else begin
            if (w_block_done)
                for (int g = 0; g < NUM_MAX_GROUPS; g++)
                    r_ptr[g] <= '0;
            if (i_cfg_loop_iter_v) begin
                r_trips[w_cfg_g][w_addr] <= i_cfg_loop_iter;
                r_ptr[w_cfg_g] <= (w_addr == LOOP_ID_W'(NUM_MAX_LOOPS - 1)) ? w_addr : w_addr + LOOP_ID_W'(1);
            end
        end
    end

`ifdef SIMD_ITER_PERF_CNT_EN
    // Saturating RUN step/stall counters, restarted by each accepted launch.
    always_ff @(posedge clk) begin
        if (reset || w_go_ok) begin
            o_perf_step_cnt  <= '0;
            o_perf_stall_cnt <= '0;
        end else if (r_state == RUN) begin
            if (i_stall)
                o_perf_stall_cnt <= (&o_perf_stall_cnt) ? o_perf_stall_cnt : o_perf_stall_cnt + 32'd1;
            else
                o_perf_step_cnt <= (&o_perf_step_cnt) ? o_perf_step_cnt : o_perf_step_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_simd_loop_iter_ctrl.sv
// tb_simd_loop_iter_ctrl: scoreboard bench for the loop-nest controller (2 loops, 4 groups).
module tb_simd_loop_iter_ctrl;
    localparam int LW = 1;
    localparam int GW = 2;
    localparam int IW = 3;
    localparam int N  = 1 << LW;
    localparam int G  = 1 << GW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_cfg_loop_iter_v = 1'b0;
    logic [IW-1:0] i_cfg_loop_iter = '0;
    logic [GW-1:0] i_cfg_loop_group_id = '0;
    logic          i_go = 1'b0;
    logic [GW-1:0] i_go_group_id = '0;
    logic          i_go_last = 1'b0;
    logic          i_stall = 1'b0;
    logic          o_busy, o_start, o_done, o_block_done;
    logic [GW-1:0] o_loop_group_id;
    logic [N:0]    o_iter_done;
`ifdef SIMD_ITER_PERF_CNT_EN
    logic [31:0]   o_perf_step_cnt, o_perf_stall_cnt;
`endif

    simd_loop_iter_ctrl #(.LOOP_ID_W(LW), .GROUP_ID_W(GW), .GROUP_ENABLED(1), .ITER_W(IW)) dut (
        .clk(clk), .reset(reset),
        .i_cfg_loop_iter_v(i_cfg_loop_iter_v), .i_cfg_loop_iter(i_cfg_loop_iter),
        .i_cfg_loop_group_id(i_cfg_loop_group_id),
        .i_go(i_go), .i_go_group_id(i_go_group_id), .i_go_last(i_go_last), .i_stall(i_stall),
        .o_busy(o_busy), .o_start(o_start), .o_loop_group_id(o_loop_group_id),
        .o_iter_done(o_iter_done), .o_done(o_done), .o_block_done(o_block_done)
`ifdef SIMD_ITER_PERF_CNT_EN
        , .o_perf_step_cnt(o_perf_step_cnt), .o_perf_stall_cnt(o_perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int t_start = 0;
    int t_done = 0;

    // Reference model: trip table and config pointers; steps are derived arithmetically.
    int tr [G][N];
    int ptr [G];
    logic [N:0] q_it [$];
    int         q_start [$];
    bit         q_done [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    task automatic m_reset();
        for (int g = 0; g < G; g++) begin
            ptr[g] = 0;
            for (int i = 0; i < N; i++) tr[g][i] = 0;
        end
    endtask

    // Step k of a nest wraps loop i when k is a multiple of the product of radices of loops i..N-1.
    function automatic logic [N:0] exp_bits(input int g, input int k);
        logic [N:0] b;
        int p;
        b = '0;
        b[N] = 1'b1;
        p = 1;
        for (int i = N - 1; i >= 0; i--) begin
            p = p * (tr[g][i] + 1);
            b[i] = (k % p) == 0;
        end
        return b;
    endfunction

    task automatic cfg(input int g, input int v);
        i_cfg_loop_iter_v = 1'b1;
        i_cfg_loop_iter = IW'(v);
        i_cfg_loop_group_id = GW'(g);
        @(posedge clk) #1;
        i_cfg_loop_iter_v = 1'b0;
        tr[g][ptr[g]] = v;
        if (ptr[g] < N - 1) ptr[g]++;
    endtask

    task automatic launch(input int g, input bit last, output int t0);
        int tot;
        for (int n = 0; n < 100 && o_busy; n++) @(posedge clk) #1;
        i_go = 1'b1;
        i_go_group_id = GW'(g);
        i_go_last = last;
        t0 = cyc;
        @(posedge clk) #1;
        i_go = 1'b0;
        i_go_last = 1'b0;
        tot = 1;
        for (int i = 0; i < N; i++) tot = tot * (tr[g][i] + 1);
        q_start.push_back(g);
        for (int k = 1; k <= tot; k++) q_it.push_back(exp_bits(g, k));
        q_done.push_back(last);
        if (last) for (int h = 0; h < G; h++) ptr[h] = 0;
    endtask

    // mode 0: no stall, 1: stall cycles t0+5..t0+8, 2: random stall.
    task automatic finish(input int mode, input int t0);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            i_stall = (mode == 1) ? (cyc >= t0 + 5 && cyc <= t0 + 8) :
                      (mode == 2) ? ($urandom_range(2) == 0) : 1'b0;
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk) #1;
        end
        i_stall = 1'b0;
        if (!ok) fail_now("finish_timeout");
    endtask

    // Monitor: pops expected responses whenever the DUT presents start, a step or done.
    always @(negedge clk) begin
        if (!reset) begin
            if (i_stall && o_busy) chk("no_step_while_stall", 64'(o_iter_done), 64'd0);
            if (o_start) begin
                t_start = cyc;
                if (q_start.size() == 0) fail_now("unexpected_start");
                else chk("start_group", 64'(o_loop_group_id), 64'(q_start.pop_front()));
            end
            if (o_iter_done != '0) begin
                if (q_it.size() == 0) fail_now("unexpected_iter_done");
                else chk("iter_done", 64'(o_iter_done), 64'(q_it.pop_front()));
            end
            if (o_done) begin
                t_done = cyc;
                if (q_done.size() == 0) fail_now("unexpected_done");
                else begin
                    chk("block_done", 64'(o_block_done), 64'(q_done.pop_front()));
                    chk("steps_left_at_done", 64'(q_it.size()), 64'd0);
                end
            end
            if (o_block_done && !o_done) fail_now("block_done_without_done");
        end
    end

    initial begin
        int t0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_start", 64'(o_start), 64'd0);
        chk("rst_iter_done", 64'(o_iter_done), 64'd0);
        chk("rst_done", 64'({o_done, o_block_done}), 64'd0);
        chk("rst_group", 64'(o_loop_group_id), 64'd0);
        @(posedge clk) #1;

        cfg(0, 1);
        cfg(0, 2);
        launch(0, 1'b0, t0);
        finish(0, t0);
        chk("start_latency", 64'(t_start), 64'(t0 + 1));
        chk("done_latency", 64'(t_done), 64'(t0 + 9));

        launch(0, 1'b0, t0);
        finish(1, t0);
        chk("stall_done_latency", 64'(t_done), 64'(t0 + 13));
`ifdef SIMD_ITER_PERF_CNT_EN
        chk("perf_step", 64'(o_perf_step_cnt), 64'd6);
        chk("perf_stall", 64'(o_perf_stall_cnt), 64'd4);
`endif

        launch(2, 1'b0, t0);
        finish(0, t0);
        chk("unconfigured_done_latency", 64'(t_done), 64'(t0 + 4));

        cfg(1, 3);
        launch(1, 1'b1, t0);
        finish(2, t0);
        cfg(1, 5);
        launch(1, 1'b0, t0);
        finish(0, t0);

        launch(0, 1'b0, t0);
        repeat (4) @(posedge clk) #1;
        i_go = 1'b1;
        i_go_group_id = 2'd3;
        @(posedge clk) #1;
        i_go = 1'b0;
        chk("group_held_on_busy_go", 64'(o_loop_group_id), 64'd0);
        finish(0, t0);
        chk("busy_go_done_latency", 64'(t_done), 64'(t0 + 9));

        for (int r = 0; r < 25; r++) begin
            int nc;
            nc = $urandom_range(3);
            for (int c = 0; c < nc; c++) cfg($urandom_range(G - 1), $urandom_range(3));
            launch($urandom_range(G - 1), $urandom_range(3) == 0, t0);
            finish(2, t0);
        end

        cfg(3, 7);
        cfg(3, 7);
        launch(3, 1'b0, t0);
        repeat (6) @(posedge clk) #1;
        reset = 1'b1;
        q_it.delete();
        q_start.delete();
        q_done.delete();
        m_reset();
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrun_rst_busy", 64'(o_busy), 64'd0);
        chk("midrun_rst_iter_done", 64'(o_iter_done), 64'd0);
        for (int n = 0; n < 5; n++) begin
            chk("midrun_rst_no_done", 64'(o_done), 64'd0);
            @(negedge clk);
        end
        @(posedge clk) #1;
        launch(0, 1'b0, t0);
        finish(0, t0);
        chk("post_rst_trips_cleared", 64'(t_done), 64'(t0 + 4));

        chk("queues_drained", 64'(q_it.size() + q_start.size() + q_done.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
